// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the core-side memory bus: arbiter states,
// bus owner encoding, access-size modes and the decoder's ROM/RAM windows.
package mem_bus_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  localparam logic [1:0] HB_WORD = 2'b10;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_BYTE = 2'b00;

  localparam logic [31:0] ROM_BASE = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE = 32'h0000_0100;
  localparam logic [31:0] RAM_BASE = 32'h0000_0100;
  localparam logic [31:0] RAM_SIZE = 32'h0000_0100;

  // Unsigned wrap makes addresses below the base fall outside the window.
  function automatic logic in_ram(input logic [31:0] addr);
    return (addr - RAM_BASE) < RAM_SIZE;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: combinational grant while enabled, with
// a last-owner register so a tie always goes to the other master.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output owner_e     winner_o
);

  owner_e last_q;

  // Bit 0 is IFU, bit 1 is LSU.
  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i == 2'b11) begin
        gnt_o = (last_q == OWN_LSU) ? 2'b01 : 2'b10;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  assign winner_o = gnt_o[1] ? OWN_LSU : OWN_IFU;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= OWN_LSU;
    end else if (|gnt_o) begin
      last_q <= winner_o;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the core memory bus between instruction fetch and load/store with
// one access in flight, round-robin grants and a fixed read latency.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned CNT_W      = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ifu_req_i,
  input  logic [31:0] ifu_addr_i,
  output logic        ifu_gnt_o,
  output logic        ifu_rvalid_o,
  output logic [31:0] ifu_rdata_o,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_hb_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_gnt_o,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic        bus_we_o,
  output logic [1:0]  bus_hb_o,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LATENCY - 1);

  state_e           state_q;
  owner_e           owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      bus_addr_q;
  logic [31:0]      bus_wdata_q;
  logic             bus_we_q;
  logic [1:0]       bus_hb_q;

  logic [1:0] gnt;
  owner_e     winner;
  logic       arb_en;
  logic       last_cyc;

  // Grants are held off while reset is asserted so every output reads 0.
  assign arb_en = rst_ni && (state_q == IDLE);

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (arb_en),
    .req_i    ({lsu_req_i, ifu_req_i}),
    .gnt_o    (gnt),
    .winner_o (winner)
  );

  assign ifu_gnt_o = gnt[0];
  assign lsu_gnt_o = gnt[1];

  assign last_cyc = (state_q == ACCESS) && (cnt_q == CNT_LAST);
  assign cnt_d    = (cnt_q == CNT_LAST) ? cnt_q : cnt_q + CNT_W'(1);

  assign ifu_rvalid_o = last_cyc && (owner_q == OWN_IFU);
  assign lsu_rvalid_o = last_cyc && (owner_q == OWN_LSU);
  assign ifu_rdata_o  = ifu_rvalid_o ? bus_rdata_i : 32'd0;
  assign lsu_rdata_o  = lsu_rvalid_o ? bus_rdata_i : 32'd0;

  assign bus_req_o   = (state_q == ACCESS);
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_we_o    = bus_we_q;
  assign bus_hb_o    = bus_hb_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IFU;
      cnt_q       <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_we_q    <= 1'b0;
      bus_hb_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|gnt) begin
            state_q <= ACCESS;
            owner_q <= winner;
            cnt_q   <= '0;
            if (winner == OWN_IFU) begin
              bus_addr_q  <= ifu_addr_i;
              bus_wdata_q <= '0;
              bus_we_q    <= 1'b0;
              bus_hb_q    <= HB_WORD;
            end else begin
              bus_addr_q  <= lsu_addr_i;
              bus_wdata_q <= lsu_wdata_i;
              bus_we_q    <= lsu_we_i;
              bus_hb_q    <= lsu_hb_i;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_d;
          // Address and mode stay put after the access; only the strobes drop.
          if (cnt_q == CNT_LAST) begin
            state_q  <= IDLE;
            bus_we_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: RD_LATENCY=1 and RD_LATENCY=3 instances share
// stimulus and are each compared every cycle against a transaction model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req;
  logic [31:0] ifu_addr;
  logic        lsu_req;
  logic        lsu_we;
  logic [1:0]  lsu_hb;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic [31:0] bus_rdata;

  logic        ifu_gnt    [2];
  logic        ifu_rvalid [2];
  logic [31:0] ifu_rdata  [2];
  logic        lsu_gnt    [2];
  logic        lsu_rvalid [2];
  logic [31:0] lsu_rdata  [2];
  logic        bus_req    [2];
  logic [31:0] bus_addr   [2];
  logic [31:0] bus_wdata  [2];
  logic        bus_we     [2];
  logic [1:0]  bus_hb     [2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RD_LATENCY(1), .CNT_W(4)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
    .ifu_gnt_o(ifu_gnt[0]), .ifu_rvalid_o(ifu_rvalid[0]), .ifu_rdata_o(ifu_rdata[0]),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_hb_i(lsu_hb),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt[0]), .lsu_rvalid_o(lsu_rvalid[0]), .lsu_rdata_o(lsu_rdata[0]),
    .bus_req_o(bus_req[0]), .bus_addr_o(bus_addr[0]), .bus_wdata_o(bus_wdata[0]),
    .bus_we_o(bus_we[0]), .bus_hb_o(bus_hb[0]), .bus_rdata_i(bus_rdata)
  );

  mem_bus_arbiter #(.RD_LATENCY(3), .CNT_W(4)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr),
    .ifu_gnt_o(ifu_gnt[1]), .ifu_rvalid_o(ifu_rvalid[1]), .ifu_rdata_o(ifu_rdata[1]),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_hb_i(lsu_hb),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
    .lsu_gnt_o(lsu_gnt[1]), .lsu_rvalid_o(lsu_rvalid[1]), .lsu_rdata_o(lsu_rdata[1]),
    .bus_req_o(bus_req[1]), .bus_addr_o(bus_addr[1]), .bus_wdata_o(bus_wdata[1]),
    .bus_we_o(bus_we[1]), .bus_hb_o(bus_hb[1]), .bus_rdata_i(bus_rdata)
  );

  // Model: a grant in cycle c occupies the bus for cycles c+1..c+lat and
  // returns rvalid in cycle c+lat; the arbiter is free again from c+lat+1.
  int          lat     [2];
  int          free_at [2];
  int          own     [2];
  int          last    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        m_we    [2];
  logic [1:0]  m_hb    [2];
  int          dut_gnt [2][2];
  int          dut_rv  [2][2];
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          gq_win[$];
  int          gq_cyc[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      free_at[k] = 0;
      own[k]     = 0;
      last[k]    = 1;
      m_addr[k]  = '0;
      m_wdata[k] = '0;
      m_we[k]    = 1'b0;
      m_hb[k]    = '0;
      for (int m = 0; m < 2; m++) begin
        dut_gnt[k][m] = 0;
        dut_rv[k][m]  = 0;
      end
    end
  endtask

  task automatic check_cycle(input int k);
    bit    busy;
    bit    rv;
    int    win;
    string p;
    p    = $sformatf("L%0d", lat[k]);
    busy = (cyc < free_at[k]);
    rv   = busy && (cyc == free_at[k] - 1);
    win  = -1;
    if (!busy && rst_n) begin
      if (ifu_req && lsu_req) win = 1 - last[k];
      else if (ifu_req)       win = 0;
      else if (lsu_req)       win = 1;
    end
    check_eq({p, " gnt{ifu,lsu}"}, {ifu_gnt[k], lsu_gnt[k]}, {(win == 0), (win == 1)});
    check_eq({p, " rvalid{ifu,lsu}"}, {ifu_rvalid[k], lsu_rvalid[k]},
             {(rv && own[k] == 0), (rv && own[k] == 1)});
    check_eq({p, " ifu_rdata"}, ifu_rdata[k], (rv && own[k] == 0) ? bus_rdata : 32'd0);
    if (!(rv && own[k] == 1 && m_we[k]))
      check_eq({p, " lsu_rdata"}, lsu_rdata[k], (rv && own[k] == 1) ? bus_rdata : 32'd0);
    check_eq({p, " bus_req"}, bus_req[k], busy);
    check_eq({p, " bus_we"}, bus_we[k], busy && m_we[k]);
    check_eq({p, " bus_addr"}, bus_addr[k], m_addr[k]);
    check_eq({p, " bus_hb"}, bus_hb[k], m_hb[k]);
    check_eq({p, " bus_wdata"}, bus_wdata[k], m_wdata[k]);

    dut_gnt[k][0] += int'(ifu_gnt[k]);
    dut_gnt[k][1] += int'(lsu_gnt[k]);
    dut_rv[k][0]  += int'(ifu_rvalid[k]);
    dut_rv[k][1]  += int'(lsu_rvalid[k]);
    if (k == 0 && (ifu_gnt[0] || lsu_gnt[0])) begin
      gq_win.push_back(lsu_gnt[0] ? 1 : 0);
      gq_cyc.push_back(cyc);
    end

    if (rv)
      $display("%s txn %s addr=%h we=%0d hb=%b rdata=%h", p, own[k] ? "LSU" : "IFU",
               m_addr[k], m_we[k], m_hb[k], bus_rdata);
    if (win >= 0) begin
      if (win == 0) begin
        m_addr[k] = ifu_addr; m_wdata[k] = '0; m_we[k] = 1'b0; m_hb[k] = 2'b10;
      end else begin
        m_addr[k] = lsu_addr; m_wdata[k] = lsu_wdata; m_we[k] = lsu_we; m_hb[k] = lsu_hb;
      end
      own[k]     = win;
      last[k]    = win;
      free_at[k] = cyc + 1 + lat[k];
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge; outputs checked on the falling edge.
  task automatic step();
    @(negedge clk);
    check_cycle(0);
    check_cycle(1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int n);
    ifu_req = 1'b0;
    lsu_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    lat[0] = 1; lat[1] = 3;
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    ifu_req = 1'b0; ifu_addr = '0;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_hb = '0; lsu_addr = '0; lsu_wdata = '0;
    bus_rdata = '0;
    model_reset();
    ifu_req = 1'b1; lsu_req = 1'b1;
    step(); step();
    ifu_req = 1'b0; lsu_req = 1'b0;
    rst_n = 1'b1;
    step();

    // IFU read from ROM 0x04
    ifu_req = 1'b1; ifu_addr = 32'h04; bus_rdata = 32'hDEAD_BEEF;
    step();
    drain(5);

    // LSU byte store to RAM 0x104
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_hb = 2'b00; lsu_addr = 32'h104; lsu_wdata = 32'hAA;
    step();
    lsu_we = 1'b0;
    drain(5);

    // Both masters requesting continuously
    gq_win.delete(); gq_cyc.delete();
    ifu_req = 1'b1; ifu_addr = 32'h10; lsu_req = 1'b1; lsu_addr = 32'h120; lsu_we = 1'b0;
    for (int i = 0; i < 16; i++) step();
    drain(5);
    check_eq("alt grant count", gq_win.size(), 8);
    for (int i = 0; i < gq_win.size(); i++) begin
      check_eq("alt grant owner", gq_win[i], i % 2);
      if (i > 0) check_eq("alt grant spacing", gq_cyc[i] - gq_cyc[i-1], 2);
    end

    // LSU load 0x180 with an IFU request queued behind it
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_hb = 2'b10; lsu_addr = 32'h180; bus_rdata = 32'h1234_5678;
    step();
    lsu_req = 1'b0; ifu_req = 1'b1; ifu_addr = 32'h20;
    for (int i = 0; i < 5; i++) step();
    drain(5);

    // Asynchronous reset in the middle of an access
    ifu_req = 1'b1; ifu_addr = 32'h08;
    step();
    ifu_req = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    ifu_req = 1'b1; lsu_req = 1'b1; lsu_addr = 32'h140;
    #1;
    check_cycle(0);
    check_cycle(1);
    @(posedge clk); cyc++; #1;
    step(); step();
    rst_n = 1'b1;
    step();
    drain(5);

    // LSU request pulse while the bus is busy with IFU
    ifu_req = 1'b1; ifu_addr = 32'h0C;
    step();
    ifu_req = 1'b0; lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 32'h1F0; lsu_wdata = 32'h55;
    step();
    lsu_req = 1'b0; lsu_we = 1'b0;
    drain(5);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      ifu_req   = ($urandom_range(0, 3) != 0);
      lsu_req   = ($urandom_range(0, 2) != 0);
      ifu_addr  = {22'd0, 8'($urandom_range(0, 63)), 2'b00};
      lsu_addr  = {22'd0, 10'($urandom_range(0, 767))};
      lsu_we    = 1'($urandom_range(0, 1));
      lsu_hb    = 2'($urandom_range(0, 2));
      lsu_wdata = $urandom;
      bus_rdata = $urandom;
      step();
    end
    drain(6);

    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("L%0d ifu rvalid==gnt count", lat[k]), dut_rv[k][0], dut_gnt[k][0]);
      check_eq($sformatf("L%0d lsu rvalid==gnt count", lat[k]), dut_rv[k][1], dut_gnt[k][1]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
